// File: rtl/bus_cycle_ctrl.sv
// 8085-style bus cycle controller: sequences T1-T2-[TW]-T3 machine cycles on the
// multiplexed AD bus, drives the strobes/status and grants HOLD between cycles.
module bus_cycle_ctrl #(
    parameter int unsigned MAX_WAIT   = 0,
    parameter logic [7:0]  NOP_OPCODE = 8'h00
) (
    input  logic        phi1,
    input  logic        resetn,
    input  logic        cyc_req,
    input  logic [2:0]  cyc_type,
    input  logic [15:0] cyc_addr,
    input  logic [7:0]  cyc_wdata,
    output logic        cyc_ack,
    output logic        cyc_done,
    output logic        bus_err,
    output logic [7:0]  rdata,
    output logic [7:0]  next_instruction,
    output logic [7:0]  a_hi,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        INTAn,
    output logic        IOMn,
    output logic        S1,
    output logic        S0,
    input  logic        READY,
    input  logic        HOLD,
    output logic        HLDA
);

    localparam int unsigned    WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

    localparam logic [2:0] CY_OPF = 3'd0;
    localparam logic [2:0] CY_MR  = 3'd1;
    localparam logic [2:0] CY_MW  = 3'd2;
    localparam logic [2:0] CY_IOR = 3'd3;
    localparam logic [2:0] CY_IOW = 3'd4;
    localparam logic [2:0] CY_INA = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_T1    = 3'd1,
        ST_T2    = 3'd2,
        ST_TW    = 3'd3,
        ST_T3    = 3'd4,
        ST_THOLD = 3'd5
    } state_t;

    function automatic logic [2:0] status_of(input logic [2:0] t);
        logic [2:0] s;
        case (t)
            CY_OPF:  s = 3'b011;
            CY_MR:   s = 3'b010;
            CY_MW:   s = 3'b001;
            CY_IOR:  s = 3'b110;
            CY_IOW:  s = 3'b101;
            CY_INA:  s = 3'b111;
            default: s = 3'b010;
        endcase
        return s;
    endfunction

    // Illegal codes run as memory reads so the bus never sees an undefined status.
    function automatic logic [2:0] legal_type(input logic [2:0] t);
        return (t > CY_INA) ? CY_MR : t;
    endfunction

    function automatic logic is_write(input logic [2:0] t);
        return (t == CY_MW) || (t == CY_IOW);
    endfunction

    state_t         state_r, state_s;
    logic [2:0]     type_r, type_s;
    logic [15:0]    addr_r, addr_s;
    logic [7:0]     wdata_r, wdata_s;
    logic [WCW-1:0] wait_r, wait_s;
    logic           err_s;
    logic           ack_s, done_s, berr_s, hlda_s;
    logic           ale_s, rdn_s, wrn_s, intan_s, ad_oe_s;
    logic [7:0]     rdata_s, ni_s, a_hi_s, ad_out_s;
    logic [2:0]     stat_s;

    // Next-state, cycle latching and next output values (outputs follow the next state).
    always_comb begin
        state_s  = state_r;
        type_s   = type_r;
        addr_s   = addr_r;
        wdata_s  = wdata_r;
        wait_s   = wait_r;
        err_s    = 1'b0;
        rdata_s  = rdata;
        ni_s     = next_instruction;
        ack_s    = 1'b0;
        done_s   = 1'b0;
        berr_s   = 1'b0;
        hlda_s   = 1'b0;
        ale_s    = 1'b0;
        rdn_s    = 1'b1;
        wrn_s    = 1'b1;
        intan_s  = 1'b1;
        ad_oe_s  = 1'b0;
        a_hi_s   = a_hi;
        ad_out_s = ad_out;
        stat_s   = {IOMn, S1, S0};

        case (state_r)
            ST_IDLE, ST_T3: begin
                if (state_r == ST_T3 && !is_write(type_r)) begin
                    rdata_s = ad_in;
                    if (type_r == CY_OPF) begin
                        ni_s = ad_in;
                    end else begin
                        ni_s = next_instruction;
                    end
                end else begin
                    rdata_s = rdata;
                end
                if (HOLD) begin
                    state_s = ST_THOLD;
                end else if (cyc_req) begin
                    state_s = ST_T1;
                    type_s  = legal_type(cyc_type);
                    addr_s  = cyc_addr;
                    wdata_s = cyc_wdata;
                    wait_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_T1: state_s = ST_T2;
            ST_T2, ST_TW: begin
                if (READY) begin
                    state_s = ST_T3;
                end else if ((MAX_WAIT != 0) && (wait_r == WAIT_LIM)) begin
                    state_s = ST_T3;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_TW;
                    if (wait_r != {WCW{1'b1}}) begin
                        wait_s = wait_r + WCW'(1);
                    end else begin
                        wait_s = wait_r;
                    end
                end
            end
            ST_THOLD: begin
                if (HOLD) begin
                    state_s = ST_THOLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        case (state_s)
            ST_T1: begin
                ale_s    = 1'b1;
                ad_oe_s  = 1'b1;
                ad_out_s = addr_s[7:0];
                a_hi_s   = addr_s[15:8];
                ack_s    = 1'b1;
                stat_s   = status_of(type_s);
            end
            ST_T2, ST_TW, ST_T3: begin
                if (is_write(type_s)) begin
                    wrn_s    = 1'b0;
                    ad_oe_s  = 1'b1;
                    ad_out_s = wdata_s;
                end else if (type_s == CY_INA) begin
                    intan_s = 1'b0;
                end else begin
                    rdn_s = 1'b0;
                end
                done_s = (state_s == ST_T3);
                berr_s = err_s;
            end
            ST_THOLD: begin
                hlda_s = 1'b1;
                stat_s = 3'b000;
            end
            ST_IDLE: stat_s = 3'b000;
            default: stat_s = 3'b000;
        endcase
    end

    // State, latched cycle parameters and all registered outputs.
    always_ff @(posedge phi1 or negedge resetn) begin
        if (!resetn) begin
            state_r          <= ST_IDLE;
            type_r           <= CY_OPF;
            addr_r           <= 16'h0000;
            wdata_r          <= 8'h00;
            wait_r           <= '0;
            cyc_ack          <= 1'b0;
            cyc_done         <= 1'b0;
            bus_err          <= 1'b0;
            HLDA             <= 1'b0;
            ALE              <= 1'b0;
            RDn              <= 1'b1;
            WRn              <= 1'b1;
            INTAn            <= 1'b1;
            ad_oe            <= 1'b0;
            a_hi             <= 8'h00;
            ad_out           <= 8'h00;
            {IOMn, S1, S0}   <= 3'b000;
            rdata            <= 8'h00;
            next_instruction <= NOP_OPCODE;
        end else begin
            state_r          <= state_s;
            type_r           <= type_s;
            addr_r           <= addr_s;
            wdata_r          <= wdata_s;
            wait_r           <= wait_s;
            cyc_ack          <= ack_s;
            cyc_done         <= done_s;
            bus_err          <= berr_s;
            HLDA             <= hlda_s;
            ALE              <= ale_s;
            RDn              <= rdn_s;
            WRn              <= wrn_s;
            INTAn            <= intan_s;
            ad_oe            <= ad_oe_s;
            a_hi             <= a_hi_s;
            ad_out           <= ad_out_s;
            {IOMn, S1, S0}   <= stat_s;
            rdata            <= rdata_s;
            next_instruction <= ni_s;
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: expected cycle results are queued when a
// request is driven and compared when cyc_done / the T3 exit edge is observed.
module tb_bus_cycle_ctrl;

    localparam int MAXW = 3;

    logic        phi1, resetn;
    logic        cyc_req;
    logic [2:0]  cyc_type;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_wdata;
    logic        cyc_ack, cyc_done, bus_err;
    logic [7:0]  rdata, next_instruction, a_hi, ad_out, ad_in;
    logic        ad_oe, ALE, RDn, WRn, INTAn, IOMn, S1, S0, READY, HOLD, HLDA;

    bus_cycle_ctrl #(.MAX_WAIT(MAXW), .NOP_OPCODE(8'h00)) dut (
        .phi1(phi1), .resetn(resetn), .cyc_req(cyc_req), .cyc_type(cyc_type),
        .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata), .cyc_ack(cyc_ack),
        .cyc_done(cyc_done), .bus_err(bus_err), .rdata(rdata),
        .next_instruction(next_instruction), .a_hi(a_hi), .ad_out(ad_out),
        .ad_oe(ad_oe), .ad_in(ad_in), .ALE(ALE), .RDn(RDn), .WRn(WRn),
        .INTAn(INTAn), .IOMn(IOMn), .S1(S1), .S0(S0), .READY(READY),
        .HOLD(HOLD), .HLDA(HLDA)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    typedef struct {
        logic [7:0] rdata;
        logic [7:0] ni;
        logic       err;
        int         lat;
        logic [2:0] st;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ack_cnt = 0;
    logic [7:0] rdata_m = 8'h00;
    logic [7:0] ni_m = 8'h00;
    bit         pend = 1'b0;
    exp_t       pend_e;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_status(input logic [2:0] t);
        case (t)
            3'd0:    return 3'b011;
            3'd1:    return 3'b010;
            3'd2:    return 3'b001;
            3'd3:    return 3'b110;
            3'd4:    return 3'b101;
            3'd5:    return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // One clock; outputs sampled 1 ns after the edge, read data checked after the T3 exit edge.
    task automatic tick();
        @(posedge phi1);
        #1;
        if (pend) begin
            chk_eq("rdata", rdata, pend_e.rdata);
            chk_eq("next_instr", next_instruction, pend_e.ni);
            pend = 1'b0;
        end
    endtask

    task automatic do_cycle(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                            input logic [7:0] din, input int n_lo, input bit hold_t2,
                            input bit keep_req);
        exp_t e;
        exp_t got;
        int   n;
        int   strobe_n;
        bit   rd;
        logic strobe;
        rd    = !(t == 3'd2 || t == 3'd4);
        e.err = (n_lo > MAXW);
        e.lat = 3 + ((n_lo > MAXW) ? MAXW : n_lo);
        if (rd) begin
            rdata_m = din;
            if (t == 3'd0) ni_m = din;
        end
        e.rdata = rdata_m;
        e.ni    = ni_m;
        e.st    = exp_status(t);
        sb.push_back(e);
        cyc_req = 1'b1; cyc_type = t; cyc_addr = a; cyc_wdata = wd;
        READY = (n_lo == 0);
        n = 0; strobe_n = 0;
        do begin
            tick();
            n++;
            if (cyc_ack) begin
                ack_cnt++;
                chk_eq("ack_at_t1", n, 1);
                chk_eq("t1_ale", ALE, 1'b1);
                chk_eq("t1_a_hi", a_hi, a[15:8]);
                chk_eq("t1_ad_out", ad_out, a[7:0]);
                chk_eq("t1_status", {IOMn, S1, S0}, e.st);
                if (!keep_req) cyc_req = 1'b0;
            end else begin
                strobe = rd ? ((t == 3'd5) ? INTAn : RDn) : WRn;
                if (strobe == 1'b0) strobe_n++;
                if (n == 2) begin
                    ad_in = din;
                    chk_eq("t2_ad_oe", ad_oe, rd ? 1'b0 : 1'b1);
                    if (!rd) chk_eq("t2_ad_out", ad_out, wd);
                    if (hold_t2) HOLD = 1'b1;
                end
                READY = ((n - 2) >= n_lo);
            end
        end while (!cyc_done && n < 40);
        if (!cyc_done) chk_eq("done_timeout", 0, 1);
        if (sb.size() == 0) begin
            chk_eq("sb_underflow", 0, 1);
        end else begin
            got = sb.pop_front();
            chk_eq("bus_err", bus_err, got.err);
            chk_eq("latency", n, got.lat);
            chk_eq("strobe_clocks", strobe_n, got.lat - 1);
            chk_eq("t3_status", {IOMn, S1, S0}, got.st);
            pend_e = got;
            pend   = 1'b1;
        end
        if (!keep_req) begin
            tick();
            chk_eq("strobes_high", {RDn, WRn, INTAn, ad_oe}, 4'b1110);
        end
    endtask

    initial begin
        int acks0;
        resetn = 1'b0; cyc_req = 1'b0; cyc_type = 3'd0; cyc_addr = 16'h0000;
        cyc_wdata = 8'h00; ad_in = 8'h00; READY = 1'b1; HOLD = 1'b0;
        repeat (2) @(posedge phi1);
        #1;
        chk_eq("rst_strobes", {ALE, RDn, WRn, INTAn, ad_oe}, 5'b01110);
        chk_eq("rst_status", {IOMn, S1, S0}, 3'b000);
        chk_eq("rst_flags", {cyc_ack, cyc_done, bus_err, HLDA}, 4'b0000);
        chk_eq("rst_data", {rdata, next_instruction, a_hi, ad_out}, 32'h0);
        @(negedge phi1) resetn = 1'b1;

        do_cycle(3'd0, 16'h1234, 8'h00, 8'h3E, 0, 1'b0, 1'b0);   // OPF
        do_cycle(3'd2, 16'h8001, 8'hA5, 8'h00, 2, 1'b0, 1'b0);   // MW, 2 waits
        do_cycle(3'd3, 16'h0040, 8'h00, 8'h77, 99, 1'b0, 1'b0);  // IOR timeout
        do_cycle(3'd7, 16'h0100, 8'h00, 8'h19, 1, 1'b0, 1'b0);   // illegal -> MR

        // HOLD raised in T2 of an MR: finishes, then THOLD.
        do_cycle(3'd1, 16'h4455, 8'h00, 8'h6B, 0, 1'b1, 1'b0);
        chk_eq("thold_hlda", HLDA, 1'b1);
        chk_eq("thold_ad_oe", ad_oe, 1'b0);
        chk_eq("thold_a_hi", a_hi, 8'h44);
        tick();
        chk_eq("thold_stay", HLDA, 1'b1);
        HOLD = 1'b0;
        tick();
        chk_eq("hold_release", HLDA, 1'b0);

        // Back-to-back OPF with cyc_req held.
        acks0 = ack_cnt;
        do_cycle(3'd0, 16'h2000, 8'h00, 8'hC3, 0, 1'b0, 1'b1);
        do_cycle(3'd0, 16'h2001, 8'h00, 8'h76, 0, 1'b0, 1'b0);
        chk_eq("b2b_acks", ack_cnt - acks0, 2);

        // Reset during TW of an INA.
        cyc_req = 1'b1; cyc_type = 3'd5; cyc_addr = 16'h0038; READY = 1'b0;
        tick();
        cyc_req = 1'b0;
        tick();
        chk_eq("ina_t2_inta", INTAn, 1'b0);
        tick();
        #2 resetn = 1'b0;
        #1;
        chk_eq("rst_mid_inta", INTAn, 1'b1);
        chk_eq("rst_mid_done", cyc_done, 1'b0);
        chk_eq("rst_mid_ni", next_instruction, 8'h00);
        chk_eq("rst_mid_rdata", rdata, 8'h00);
        rdata_m = 8'h00; ni_m = 8'h00; READY = 1'b1;
        @(negedge phi1) resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("post_rst_idle", {cyc_done, cyc_ack, ALE}, 3'b000);
        end

        do_cycle(3'd1, 16'h00FF, 8'h00, 8'h5A, 1, 1'b0, 1'b0);
        chk_eq("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
